// File: rtl/tlul_host_mux.sv
// N-to-1 TL-UL host multiplexer: round-robin A-channel arbitration with in-order D routing.
// Optional per-host grant counters are built when TLUL_MUX_PERF_EN is defined.

package tlul_pkg;
  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

module tlul_host_mux
  import tlul_pkg::*;
#(
  parameter int NumHosts       = 2,
  parameter int MaxOutstanding = 4
`ifdef TLUL_MUX_PERF_EN
  , parameter int PerfCntW     = 16
`endif
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  tl_h2d_t                              tl_h_i [NumHosts],
  output tl_d2h_t                              tl_h_o [NumHosts],
  output tl_h2d_t                              tl_d_o,
  input  tl_d2h_t                              tl_d_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o,
  output logic                                 spurious_rsp_o
`ifdef TLUL_MUX_PERF_EN
  , output logic [PerfCntW-1:0]                perf_grant_cnt_o [NumHosts]
`endif
);

  localparam int IdxW = (NumHosts > 1) ? $clog2(NumHosts) : 1;
  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntW = $clog2(MaxOutstanding + 1);

  logic [IdxW-1:0] r_fifo [MaxOutstanding];
  logic [PtrW-1:0] r_wptr, r_rptr;
  logic [CntW-1:0] r_cnt;
  logic [IdxW-1:0] r_rr;
  logic            r_lock;
  logic [IdxW-1:0] r_host;
  logic            r_spur;

  logic [IdxW-1:0] w_cand, w_search, w_win, w_head, w_next_rr;
  logic            w_found, w_req, w_full, w_empty;
  logic            w_a_valid, w_a_hs, w_d_ready, w_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  // First requesting host at or above the round-robin pointer, wrapping around.
  always_comb begin
    w_found  = 1'b0;
    w_search = r_rr;
    w_cand   = r_rr;
    for (int i = 0; i < NumHosts; i++) begin
      w_cand = IdxW'((int'(r_rr) + i) % NumHosts);
      if (!w_found && tl_h_i[w_cand].a_valid) begin
        w_found  = 1'b1;
        w_search = w_cand;
      end
    end
  end

  assign w_win     = r_lock ? r_host : w_search;
  assign w_req     = r_lock ? tl_h_i[r_host].a_valid : w_found;
  assign w_full    = (r_cnt == CntW'(MaxOutstanding));
  assign w_empty   = (r_cnt == '0);
  assign w_a_valid = w_req & ~w_full;
  assign w_a_hs    = w_a_valid & tl_d_i.a_ready;
  assign w_next_rr = (w_win == IdxW'(NumHosts - 1)) ? '0 : w_win + 1'b1;

  // With nothing in flight a stray response is sunk rather than stalling the device.
  assign w_head    = r_fifo[r_rptr];
  assign w_d_ready = w_empty | tl_h_i[w_head].d_ready;
  assign w_pop     = tl_d_i.d_valid & ~w_empty & tl_h_i[w_head].d_ready;

  always_comb begin
    tl_d_o         = tl_h_i[w_win];
    tl_d_o.a_valid = w_a_valid;
    tl_d_o.d_ready = w_d_ready;
  end

  always_comb begin
    for (int h = 0; h < NumHosts; h++) begin
      tl_h_o[h]         = tl_d_i;
      tl_h_o[h].d_valid = tl_d_i.d_valid & ~w_empty & (w_head == IdxW'(h));
      tl_h_o[h].a_ready = tl_d_i.a_ready & ~w_full & (w_win == IdxW'(h));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_rr   <= '0;
      r_lock <= 1'b0;
      r_host <= '0;
      r_spur <= 1'b0;
    end else begin
      if (w_a_hs) begin
        r_wptr <= ptr_inc(r_wptr);
        r_rr   <= w_next_rr;
        r_lock <= 1'b0;
      end else if (w_a_valid) begin
        r_lock <= 1'b1;
        r_host <= w_win;
      end
      if (w_pop) r_rptr <= ptr_inc(r_rptr);
      case ({w_a_hs, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      r_spur <= tl_d_i.d_valid & w_empty;
    end
  end

  // Host-ID storage is only meaningful between the pointers, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (w_a_hs) r_fifo[r_wptr] <= w_win;
  end

  assign outstanding_o  = r_cnt;
  assign spurious_rsp_o = r_spur;

`ifdef TLUL_MUX_PERF_EN
  logic [PerfCntW-1:0] r_perf [NumHosts];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int h = 0; h < NumHosts; h++) r_perf[h] <= '0;
    end else if (w_a_hs && (r_perf[w_win] != '1)) begin
      r_perf[w_win] <= r_perf[w_win] + 1'b1;
    end
  end

  assign perf_grant_cnt_o = r_perf;
`endif

endmodule

// File: tb/tb_tlul_host_mux.sv
// Bench for tlul_host_mux: directed table, hand-written corner sequences and randomized traffic
// checked against a queue-based model of arbitration and response routing.
module tb_tlul_host_mux;
  import tlul_pkg::*;

  localparam int NH = 2;
  localparam int MO = 4;
  localparam int PW = 4;
  localparam int CW = $clog2(MO + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  tl_h2d_t       tl_h_i [NH];
  tl_d2h_t       tl_h_o [NH];
  tl_h2d_t       tl_d_o;
  tl_d2h_t       tl_d_i;
  logic [CW-1:0] outstanding;
  logic          spurious;
`ifdef TLUL_MUX_PERF_EN
  logic [PW-1:0] perf [NH];
  int            m_perf [NH];
`endif

  logic        hv [NH];
  logic [31:0] haddr [NH];
  logic [7:0]  hsrc [NH];
  logic        hdr [NH];
  logic        ar, dv;
  logic [31:0] ddata;

  int q[$];
  int m_rr, m_lockh;
  bit m_lock, m_spur;
  bit m_gnt [NH];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int h = 0; h < NH; h++) begin
      tl_h_i[h]           = '0;
      tl_h_i[h].a_valid   = hv[h];
      tl_h_i[h].a_source  = hsrc[h];
      tl_h_i[h].a_address = haddr[h];
      tl_h_i[h].a_data    = ~haddr[h];
      tl_h_i[h].a_mask    = 4'hf;
      tl_h_i[h].d_ready   = hdr[h];
    end
    tl_d_i          = '0;
    tl_d_i.a_ready  = ar;
    tl_d_i.d_valid  = dv;
    tl_d_i.d_data   = ddata;
    tl_d_i.d_source = 8'h5a;
  end

  tlul_host_mux #(
    .NumHosts(NH),
`ifdef TLUL_MUX_PERF_EN
    .PerfCntW(PW),
`endif
    .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .tl_h_i(tl_h_i),
    .tl_h_o(tl_h_o),
    .tl_d_o(tl_d_o),
    .tl_d_i(tl_d_i),
    .outstanding_o(outstanding),
`ifdef TLUL_MUX_PERF_EN
    .perf_grant_cnt_o(perf),
`endif
    .spurious_rsp_o(spurious)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: compare against the model at the falling edge, advance the model at the rising edge.
  task automatic step();
    int  win;
    bit  found, e_av, e_dv, pop;
    @(negedge clk);
    found = 1'b0;
    win   = m_rr;
    if (m_lock) begin
      win   = m_lockh;
      found = hv[win];
    end else begin
      for (int i = 0; i < NH; i++) begin
        int c;
        c = (m_rr + i) % NH;
        if (!found && hv[c]) begin
          found = 1'b1;
          win   = c;
        end
      end
    end
    e_av = found && (q.size() < MO);
    chk("a_valid", tl_d_o.a_valid, e_av);
    if (e_av) begin
      chk("a_source", tl_d_o.a_source, hsrc[win]);
      chk("a_address", tl_d_o.a_address, haddr[win]);
    end
    for (int h = 0; h < NH; h++) begin
      chk($sformatf("grant[%0d]", h), tl_h_o[h].a_ready & hv[h], e_av && ar && (h == win));
      e_dv = dv && (q.size() > 0) && (q[0] == h);
      chk($sformatf("d_valid[%0d]", h), tl_h_o[h].d_valid, e_dv);
      if (e_dv) chk($sformatf("d_data[%0d]", h), tl_h_o[h].d_data, ddata);
    end
    chk("d_ready", tl_d_o.d_ready, (q.size() == 0) ? 1'b1 : hdr[q[0]]);
    chk("outstanding", outstanding, q.size());
    chk("spurious", spurious, m_spur);
`ifdef TLUL_MUX_PERF_EN
    for (int h = 0; h < NH; h++) chk($sformatf("perf[%0d]", h), perf[h], m_perf[h]);
`endif
    pop = dv && (q.size() > 0) && hdr[q[0]];
    @(posedge clk);
    m_spur = dv && (q.size() == 0);
    if (pop) void'(q.pop_front());
    for (int h = 0; h < NH; h++) m_gnt[h] = 1'b0;
    if (e_av && ar) begin
      q.push_back(win);
      m_rr       = (win + 1) % NH;
      m_lock     = 1'b0;
      m_gnt[win] = 1'b1;
`ifdef TLUL_MUX_PERF_EN
      if (m_perf[win] < (1 << PW) - 1) m_perf[win]++;
`endif
    end else if (e_av) begin
      m_lock  = 1'b1;
      m_lockh = win;
    end
    #1;
  endtask

  task automatic do_reset();
    for (int h = 0; h < NH; h++) begin
      hv[h]  = 1'b0;
      hdr[h] = 1'b0;
    end
    ar    = 1'b0;
    dv    = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst outstanding", outstanding, 0);
    chk("rst a_valid", tl_d_o.a_valid, 0);
    chk("rst spurious", spurious, 0);
    for (int h = 0; h < NH; h++) chk($sformatf("rst d_valid[%0d]", h), tl_h_o[h].d_valid, 0);
`ifdef TLUL_MUX_PERF_EN
    for (int h = 0; h < NH; h++) chk($sformatf("rst perf[%0d]", h), perf[h], 0);
    for (int h = 0; h < NH; h++) m_perf[h] = 0;
`endif
    q.delete();
    m_rr   = 0;
    m_lock = 1'b0;
    m_spur = 1'b0;
    for (int h = 0; h < NH; h++) m_gnt[h] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit hv0, hv1, ar, dv, dr0, dr1;
    bit e_av, e_g0, e_g1, e_dv0, e_dv1, e_dr;
    int e_out;
    bit e_spur;
  } vec_t;

  vec_t tbl [10];

  initial begin
    tbl[0] = '{0,0,1,0,1,1, 0,0,0,0,0,1, 0,0};
    tbl[1] = '{1,1,1,0,1,1, 1,1,0,0,0,1, 0,0};
    tbl[2] = '{1,1,1,1,1,1, 1,0,1,1,0,1, 1,0};
    tbl[3] = '{1,1,1,1,1,1, 1,1,0,0,1,1, 1,0};
    tbl[4] = '{1,1,1,1,1,1, 1,0,1,1,0,1, 1,0};
    tbl[5] = '{0,0,1,1,1,0, 0,0,0,0,1,0, 1,0};
    tbl[6] = '{0,0,1,1,1,1, 0,0,0,0,1,1, 1,0};
    tbl[7] = '{0,0,1,1,1,1, 0,0,0,0,0,1, 0,0};
    tbl[8] = '{0,0,1,0,1,1, 0,0,0,0,0,1, 0,1};
    tbl[9] = '{0,0,1,0,1,1, 0,0,0,0,0,1, 0,0};

    haddr[0] = 32'h0000_1000; hsrc[0] = 8'h10;
    haddr[1] = 32'h0000_2000; hsrc[1] = 8'h21;
    ddata    = 32'h0;
    for (int h = 0; h < NH; h++) begin
      hv[h]  = 1'b0;
      hdr[h] = 1'b0;
    end
    ar = 1'b0;
    dv = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Directed table: alternating grants and in-order response routing.
    for (int i = 0; i < 10; i++) begin
      hv[0]  = tbl[i].hv0;
      hv[1]  = tbl[i].hv1;
      ar     = tbl[i].ar;
      dv     = tbl[i].dv;
      hdr[0] = tbl[i].dr0;
      hdr[1] = tbl[i].dr1;
      ddata  = 32'hd000_0000 + i;
      #1;
      chk($sformatf("t%0d a_valid", i), tl_d_o.a_valid, tbl[i].e_av);
      chk($sformatf("t%0d grant0", i), tl_h_o[0].a_ready & hv[0], tbl[i].e_g0);
      chk($sformatf("t%0d grant1", i), tl_h_o[1].a_ready & hv[1], tbl[i].e_g1);
      chk($sformatf("t%0d d_valid0", i), tl_h_o[0].d_valid, tbl[i].e_dv0);
      chk($sformatf("t%0d d_valid1", i), tl_h_o[1].d_valid, tbl[i].e_dv1);
      chk($sformatf("t%0d d_ready", i), tl_d_o.d_ready, tbl[i].e_dr);
      chk($sformatf("t%0d outstanding", i), outstanding, tbl[i].e_out);
      chk($sformatf("t%0d spurious", i), spurious, tbl[i].e_spur);
      step();
    end

    // FIFO full: four accepted, fifth held off until a slot is freed.
    hv[0] = 1'b1; hv[1] = 1'b0; ar = 1'b1; dv = 1'b0; hdr[0] = 1'b0; hdr[1] = 1'b0;
    repeat (4) step();
    chk("full outstanding", outstanding, 4);
    chk("full a_ready", tl_h_o[0].a_ready, 0);
    chk("full a_valid", tl_d_o.a_valid, 0);
    dv = 1'b1; hdr[0] = 1'b1;
    #1;
    chk("full+pop a_ready", tl_h_o[0].a_ready, 0);
    chk("full+pop d_valid0", tl_h_o[0].d_valid, 1);
    step();
    dv = 1'b0;
    #1;
    chk("freed outstanding", outstanding, 3);
    chk("freed a_ready", tl_h_o[0].a_ready, 1);
    step();
    chk("refill outstanding", outstanding, 4);
    hv[0] = 1'b0; dv = 1'b1;
    step();
    dv = 1'b0;
    #1;
    chk("pre-reset outstanding", outstanding, 3);
    do_reset();

    // Lock: H1 stalled by the device keeps the grant even after H0 requests.
    hv[1] = 1'b1;
    step();
    hv[0] = 1'b1;
    #1;
    chk("lock a_source", tl_d_o.a_source, 8'h21);
    chk("lock a_address", tl_d_o.a_address, 32'h0000_2000);
    step();
    step();
    ar = 1'b1;
    #1;
    chk("lock grant1", tl_h_o[1].a_ready, 1);
    chk("lock grant0", tl_h_o[0].a_ready, 0);
    step();
    hv[1] = 1'b0;
    #1;
    chk("after lock grant0", tl_h_o[0].a_ready, 1);
    chk("after lock a_source", tl_d_o.a_source, 8'h10);
    step();
    hv[0] = 1'b0; dv = 1'b1; hdr[0] = 1'b1; hdr[1] = 1'b1; ddata = 32'hcafe_0001;
    #1;
    chk("rsp order first", tl_h_o[1].d_valid, 1);
    step();
    ddata = 32'hcafe_0002;
    #1;
    chk("rsp order second", tl_h_o[0].d_valid, 1);
    step();

    // Response with nothing outstanding.
    hdr[0] = 1'b0; hdr[1] = 1'b0;
    #1;
    chk("spur d_ready", tl_d_o.d_ready, 1);
    chk("spur d_valid0", tl_h_o[0].d_valid, 0);
    chk("spur d_valid1", tl_h_o[1].d_valid, 0);
    chk("spur pre", spurious, 0);
    step();
    dv = 1'b0;
    #1;
    chk("spur pulse", spurious, 1);
    step();
    chk("spur end", spurious, 0);

    // Randomized traffic; pending requests stay stable until granted.
    for (int c = 0; c < 600; c++) begin
      for (int h = 0; h < NH; h++) begin
        if (!(hv[h] && !m_gnt[h])) begin
          hv[h]    = 1'($urandom_range(0, 1));
          haddr[h] = $urandom;
          hsrc[h]  = 8'(h * 16 + $urandom_range(0, 15));
        end
        hdr[h] = ($urandom_range(0, 3) != 0);
      end
      ar    = ($urandom_range(0, 3) != 0);
      dv    = 1'($urandom_range(0, 1));
      ddata = $urandom;
      step();
    end

`ifdef TLUL_MUX_PERF_EN
    do_reset();
    hv[0] = 1'b1; hv[1] = 1'b0; ar = 1'b1; dv = 1'b1; hdr[0] = 1'b1; hdr[1] = 1'b0;
    repeat (20) step();
    chk("perf sat h0", perf[0], 15);
    chk("perf h1", perf[1], 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
